pulse_edge_gen: RTL
===================

# pulse_edge_gen

Programmable pulse-train transmitter: the output-side counterpart of our edge-grabbing synchronizer. On a start request it drives `sign_out` through `pulse_num` high/low cycles with `high_len` and `low_len` cycle widths. It also emits single-cycle strobes that coincide with each output edge. The block sits in the sign_sync group, feeding a strobe or trigger line to another clock domain or off-chip, where the receiving end uses our edge detector.

## Interface
- `CNT_W`, 16: width of `high_len`/`low_len` and the internal phase counter.
- `NUM_W`, 8: width of `pulse_num` and `pulse_cnt`.
- `IDLE_LEVEL`, 1'b0: level of `sign_out` when not pulsing. The active level is `~IDLE_LEVEL`.

Ports:
- `clk`  input  1  sole clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `abort`  input  1  synchronous cancel; takes effect in any busy state.
- `high_len`  input  CNT_W  active-phase width in cycles; captured at start.
- `low_len`  input  CNT_W  idle-phase width in cycles; captured at start.
- `pulse_num`  input  NUM_W  number of pulses; captured at start.
- `sign_out`  output  1  registered generated signal.
- `rising_edge`  output  1  one-cycle strobe in the first cycle `sign_out`=1 after being 0.
- `falling_edge`  output  1  one-cycle strobe in the first cycle `sign_out`=0 after being 1.
- `busy`  output  1  high while a train is in progress.
- `done`  output  1  one-cycle pulse on normal completion.
- `pulse_cnt`  output  NUM_W  pulses fully completed (active plus idle phase) in the current or last train.

## Operation
- Reset values: `sign_out`=IDLE_LEVEL; `rising_edge`, `falling_edge`, `busy`, `done`=0; `pulse_cnt`=0; state=IDLE.
- Reset is honoured mid-train with no completion strobe.
- All outputs are registered.
- States:
  - IDLE: `busy`=0. If `start`=1, capture the three lengths and clear `pulse_cnt`.
    - If `pulse_num`≠0, go to ACTIVE.
    - If `pulse_num`=0, stay in IDLE and assert `done` next cycle; `sign_out` never moves.
  - ACTIVE: `sign_out`=~IDLE_LEVEL for exactly `high_len` cycles, then go to INACT.
  - INACT: `sign_out`=IDLE_LEVEL for exactly `low_len` cycles, then increment `pulse_cnt`.
    - If `pulse_cnt`+1 < `pulse_num`, go to ACTIVE.
    - Otherwise go to IDLE with `done`=1.
- Zero widths: a captured `high_len`=0 or `low_len`=0 is treated as 1. There is no zero-width phase and no glitch.
- Input changes: changes to `high_len`, `low_len` and `pulse_num` while `busy` are ignored.
- `start` while busy is ignored; it is not queued.
- Abort: `abort`=1 while busy forces the next cycle to IDLE with `sign_out`=IDLE_LEVEL and `busy`=0.
  - `done` stays 0 and `pulse_cnt` holds the count of completed pulses.
  - If `sign_out` was active, the edge strobe for that transition fires.
  - `abort` has priority over phase advance and over `start`. `abort` in IDLE has no effect.
- Edge strobes: `rising_edge`/`falling_edge` follow the physical transition of `sign_out`, independent of IDLE_LEVEL. They never fire without a `sign_out` change.
- Phase counter: CNT_W bits, counts 1 up to the captured length. No wrap occurs; all-ones length is legal (2^CNT_W−1 cycles).

## Timing
- Start latency: `start` sampled at edge t gives `busy`=1 and `sign_out` active from cycle t+1, with `rising_edge`=1 in cycle t+1.
- Each pulse occupies exactly `high_len`+`low_len` cycles. The whole train occupies `pulse_num`×(`high_len`+`low_len`) cycles with `busy`=1.
- The trailing low phase of the last pulse is included.
- Completion: the cycle after the final INACT cycle has `busy`=0, `done`=1 and `pulse_cnt`=`pulse_num`.
  - `start` is accepted in that same cycle, giving back-to-back trains with no extra idle cycle.
- Abort latency: 1 cycle from `abort` sampled to `busy`=0 and `sign_out`=IDLE_LEVEL.
- `pulse_num`=0: `done` is asserted at t+1 and `busy` never rises.

## Test plan
- Basic train: IDLE_LEVEL=0, high=3, low=2, num=2, start at cycle 10.
  - `sign_out` high in cycles 11–13 and 16–18, low in 14–15 and 19–20.
  - `rising_edge` at 11 and 16; `falling_edge` at 14 and 19.
  - `done` at 21 with `pulse_cnt`=2; `busy` set in 11–20.
- Zero and degenerate lengths: high=0, low=0, num=3 gives alternating 1,0,1,0,1,0 from t+1. num=0 gives `done` at t+1, `busy` never 1, `sign_out` flat.
- Abort mid-high: high=5, low=5, num=4, abort in the third cycle of pulse 2.
  - Next cycle: `sign_out`=0, `falling_edge`=1, `busy`=0, `done`=0, `pulse_cnt`=1.
- Back-to-back and ignored start: assert `start` during `busy`, which must be ignored.
  - Assert `start` in the `done` cycle: the next train's `rising_edge` follows 1 cycle later with no gap.
  - New lengths applied while busy affect only the next train.
- Polarity: IDLE_LEVEL=1, high=2, low=1, num=1. Reset value is 1.
  - `sign_out`=0 for 2 cycles with `falling_edge` first, then 1 for 1 cycle with `rising_edge`, then `done`.
- Async reset: assert `rst_n`=0 mid-ACTIVE between clock edges.
  - Outputs go to reset values immediately without waiting for `clk`.
  - After release, the block idles until the next `start`.

Source files
------------

// File: rtl/pulse_edge_gen.sv
// -----------------------------------------------------------------------------
// pulse_edge_gen
//
// Programmable pulse-train transmitter. A start request in IDLE captures
// high_len, low_len and pulse_num, then drives sign_out through pulse_num
// active/idle phase pairs. Single-cycle strobes mark every physical edge of
// sign_out, and done marks normal completion.
//
// Parameters:
//   CNT_W      width of high_len / low_len and the phase counter
//   NUM_W      width of pulse_num / pulse_cnt
//   IDLE_LEVEL level of sign_out when not pulsing (active level is inverse)
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   train request, sampled only in IDLE
//   abort        in   synchronous cancel while busy
//   high_len     in   active-phase width in cycles (0 behaves as 1)
//   low_len      in   idle-phase width in cycles (0 behaves as 1)
//   pulse_num    in   number of pulses (0 completes immediately)
//   sign_out     out  registered generated signal
//   rising_edge  out  strobe in the first cycle sign_out is 1 after 0
//   falling_edge out  strobe in the first cycle sign_out is 0 after 1
//   busy         out  train in progress
//   done         out  one-cycle strobe on normal completion
//   pulse_cnt    out  pulses fully completed in current or last train
// -----------------------------------------------------------------------------
module pulse_edge_gen #(
    parameter int   CNT_W      = 16,
    parameter int   NUM_W      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] pulse_num,
    output logic             sign_out,
    output logic             rising_edge,
    output logic             falling_edge,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    localparam logic             ACTIVE_LEVEL = ~IDLE_LEVEL;
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [NUM_W-1:0] NUM_ONE      = {{(NUM_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ZERO     = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_INACT  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] phase_cnt, phase_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] pulse_cnt_d;
    logic [NUM_W-1:0] pulse_inc;
    logic             sign_d;
    logic             rise_d;
    logic             fall_d;
    logic             busy_d;
    logic             done_d;

    assign pulse_inc = pulse_cnt + NUM_ONE;

    // Next-state and next-output logic. Every output is computed here as the
    // value it will hold in the following cycle, so the register stage below
    // makes all outputs registered. The phase counter runs 1..captured length
    // and lengths are stored already clamped to at least 1, so the equality
    // compare never needs a zero case and an all-ones length cannot wrap.
    always_comb begin
        state_d     = state;
        phase_d     = phase_cnt;
        high_d      = high_q;
        low_d       = low_q;
        num_d       = num_q;
        pulse_cnt_d = pulse_cnt;
        sign_d      = sign_out;
        done_d      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    high_d      = (high_len == CNT_ZERO) ? CNT_ONE : high_len;
                    low_d       = (low_len == CNT_ZERO) ? CNT_ONE : low_len;
                    num_d       = pulse_num;
                    pulse_cnt_d = NUM_ZERO;
                    if (pulse_num != NUM_ZERO) begin
                        state_d = S_ACTIVE;
                        phase_d = CNT_ONE;
                        sign_d  = ACTIVE_LEVEL;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end

            S_ACTIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sign_d  = IDLE_LEVEL;
                end else if (phase_cnt == high_q) begin
                    state_d = S_INACT;
                    phase_d = CNT_ONE;
                    sign_d  = IDLE_LEVEL;
                end else begin
                    phase_d = phase_cnt + CNT_ONE;
                end
            end

            S_INACT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sign_d  = IDLE_LEVEL;
                end else if (phase_cnt == low_q) begin
                    pulse_cnt_d = pulse_inc;
                    if (pulse_inc < num_q) begin
                        state_d = S_ACTIVE;
                        phase_d = CNT_ONE;
                        sign_d  = ACTIVE_LEVEL;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_cnt + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                sign_d  = IDLE_LEVEL;
            end
        endcase

        // Strobes come from the physical transition only, so they are
        // independent of IDLE_LEVEL and cannot fire without a level change.
        rise_d = (sign_d != sign_out) && (sign_d == 1'b1);
        fall_d = (sign_d != sign_out) && (sign_d == 1'b0);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase_cnt    <= CNT_ZERO;
            high_q       <= CNT_ONE;
            low_q        <= CNT_ONE;
            num_q        <= NUM_ZERO;
            pulse_cnt    <= NUM_ZERO;
            sign_out     <= IDLE_LEVEL;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            phase_cnt    <= phase_d;
            high_q       <= high_d;
            low_q        <= low_d;
            num_q        <= num_d;
            pulse_cnt    <= pulse_cnt_d;
            sign_out     <= sign_d;
            rising_edge  <= rise_d;
            falling_edge <= fall_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule
